// File: rtl/wb_master_pkg.sv
// Shared Wishbone definitions: FSM state encoding and bus data/select widths.
package wb_master_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_SEL_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } wb_state_e;

endpackage

// File: rtl/wb_timeout_cnt.sv
// Saturating watchdog counter for an open bus cycle; expired_o flags the terminal count.
module wb_timeout_cnt #(
  parameter int MAX_COUNT = 255
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = (MAX_COUNT > 0) ? $clog2(MAX_COUNT + 1) : 1;
  localparam logic [CW-1:0] MAX_C = CW'(MAX_COUNT);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != MAX_C)) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // A zero limit keeps the counter parked at 0 and never reports expiry.
  assign expired_o = (MAX_COUNT != 0) && (cnt_q == MAX_C);

endmodule

// File: rtl/wb_master.sv
// Wishbone pipelined initiator: one valid/ready request becomes one bus transaction
// and exactly one response pulse (ack, slave error or watchdog timeout).
//   state   | meaning
//   ST_IDLE | ready for a request, bus idle
//   ST_REQ  | cyc+stb driven, waiting for stall to drop
//   ST_WAIT | strobe accepted, waiting for ack/err/timeout
//   ST_RESP | one-cycle response pulse
module wb_master
  import wb_master_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [WB_DATA_W-1:0]  req_wdata_i,
  input  logic [WB_SEL_W-1:0]   req_sel_i,
  output logic                  rsp_valid_o,
  output logic [WB_DATA_W-1:0]  rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [ADDR_WIDTH-1:0] wb_addr_o,
  output logic [WB_DATA_W-1:0]  wb_data_o,
  output logic [WB_SEL_W-1:0]   wb_sel_o,
  input  logic                  wb_ack_i,
  input  logic                  wb_err_i,
  input  logic                  wb_stall_i,
  input  logic [WB_DATA_W-1:0]  wb_data_i
);

  wb_state_e             state_q;
  logic                  req_ready_q;
  logic                  cyc_q;
  logic                  stb_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [WB_DATA_W-1:0]  wdata_q;
  logic [WB_SEL_W-1:0]   sel_q;
  logic                  rsp_valid_q;
  logic [WB_DATA_W-1:0]  rsp_rdata_q;
  logic                  rsp_err_q;

  logic                  accept;
  logic                  bus_open;
  logic                  expired;
  logic                  rsp_fire_d;
  logic                  rsp_err_d;
  logic [WB_DATA_W-1:0]  rsp_rdata_d;

  assign accept   = (state_q == ST_IDLE) && req_ready_q && req_valid_i;
  assign bus_open = (state_q == ST_REQ) || (state_q == ST_WAIT);

  wb_timeout_cnt #(
    .MAX_COUNT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (clk),
    .resetn    (resetn),
    .clr_i     (accept),
    .en_i      (bus_open),
    .expired_o (expired)
  );

  // Slave termination beats the watchdog; err beats ack.
  always_comb begin
    rsp_fire_d  = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    if (((state_q == ST_REQ) && !wb_stall_i) || (state_q == ST_WAIT)) begin
      if (wb_err_i) begin
        rsp_fire_d = 1'b1;
        rsp_err_d  = 1'b1;
      end else if (wb_ack_i) begin
        rsp_fire_d  = 1'b1;
        rsp_rdata_d = we_q ? '0 : wb_data_i;
      end
    end
    if (!rsp_fire_d && bus_open && expired) begin
      rsp_fire_d = 1'b1;
      rsp_err_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      req_ready_q <= 1'b0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      sel_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q     <= ST_REQ;
            req_ready_q <= 1'b0;
            cyc_q       <= 1'b1;
            stb_q       <= 1'b1;
            we_q        <= req_we_i;
            addr_q      <= req_addr_i;
            wdata_q     <= req_wdata_i;
            sel_q       <= req_sel_i;
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        ST_REQ, ST_WAIT: begin
          if (rsp_fire_d) begin
            state_q     <= ST_RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            sel_q       <= '0;
          end else if ((state_q == ST_REQ) && !wb_stall_i) begin
            state_q <= ST_WAIT;
            stb_q   <= 1'b0;
          end
        end
        ST_RESP: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = stb_q;
  assign wb_we_o     = we_q;
  assign wb_addr_o   = addr_q;
  assign wb_data_o   = wdata_q;
  assign wb_sel_o    = sel_q;

endmodule

// File: tb/tb_wb_master.sv
// Bench for wb_master: directed vector table, random traffic against a memory
// reference model, plus hand-written timeout and reset-abort sequences.
module tb_wb_master;

  localparam int AW = 32;
  localparam int TO = 8;
  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam int M_ACK = 0, M_ERR = 1, M_BOTH = 2, M_NONE = 3, M_ACK_TO = 4;
  localparam int NVEC = 11;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    int          stall;
    int          mode;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  logic          clk, resetn;
  logic          req_valid_i, req_ready_o, req_we_i;
  logic [AW-1:0] req_addr_i;
  logic [31:0]   req_wdata_i;
  logic [3:0]    req_sel_i;
  logic          rsp_valid_o, rsp_err_o;
  logic [31:0]   rsp_rdata_o;
  logic          wb_cyc_o, wb_stb_o, wb_we_o;
  logic [AW-1:0] wb_addr_o;
  logic [31:0]   wb_data_o;
  logic [3:0]    wb_sel_o;
  logic          wb_ack_i, wb_err_i, wb_stall_i;
  logic [31:0]   wb_data_i;

  wb_master #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_sel_i(req_sel_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o), .wb_sel_o(wb_sel_o),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_stall_i(wb_stall_i),
    .wb_data_i(wb_data_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [31:0] slv_mem [16];
  logic [31:0] ref_mem [16];
  vec_t tbl [NVEC];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'(a[5:2]);
  endfunction

  function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] sel, input int stall, input int mode,
                              input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.sel = sel; v.stall = stall; v.mode = mode;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat;
    return v;
  endfunction

  // Issues one request and plays the slave; lat counts cycles from acceptance to rsp_valid_o.
  task automatic run_txn(input string tag, input vec_t v, output logic [31:0] rd,
                         output logic er, output int lat);
    int guard;
    int ack_k;
    bit got;
    logic cap_we;
    logic [31:0] cap_addr, cap_data;
    logic [3:0] cap_sel;
    guard = 0; got = 0; lat = -1; rd = 'x; er = 1'bx;
    cap_we = 1'b0; cap_addr = '0; cap_data = '0; cap_sel = '0;
    while (req_ready_o !== 1'b1 && guard < 20) begin
      step();
      guard++;
    end
    check1({tag, " ready"}, req_ready_o, 1'b1);
    req_valid_i = 1'b1; req_we_i = v.we; req_addr_i = v.addr;
    req_wdata_i = v.wdata; req_sel_i = v.sel;
    step();
    req_valid_i = 1'b0; req_we_i = ~v.we; req_addr_i = $urandom;
    req_wdata_i = $urandom; req_sel_i = 4'($urandom);
    ack_k = (v.mode == M_NONE) ? -1 : (v.mode == M_ACK_TO) ? TO + 1 : v.stall + 2;
    for (int k = 1; k <= TO + 6 && !got; k++) begin
      if (rsp_valid_o === 1'b1) begin
        got = 1; lat = k; rd = rsp_rdata_o; er = rsp_err_o;
        check1({tag, " cyc at rsp"}, wb_cyc_o, 1'b0);
        check1({tag, " ready at rsp"}, req_ready_o, 1'b0);
      end else if (k <= v.stall + 1) begin
        check1($sformatf("%s stb k%0d", tag, k), wb_stb_o, 1'b1);
        check1($sformatf("%s cyc k%0d", tag, k), wb_cyc_o, 1'b1);
        check1($sformatf("%s we k%0d", tag, k), wb_we_o, v.we);
        check($sformatf("%s addr k%0d", tag, k), wb_addr_o, v.addr);
        check($sformatf("%s data k%0d", tag, k), wb_data_o, v.wdata);
        check($sformatf("%s sel k%0d", tag, k), {28'd0, wb_sel_o}, {28'd0, v.sel});
      end else begin
        check1($sformatf("%s stb low k%0d", tag, k), wb_stb_o, 1'b0);
        check1($sformatf("%s cyc high k%0d", tag, k), wb_cyc_o, 1'b1);
      end
      if (!got) begin
        wb_stall_i = (k <= v.stall);
        wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_data_i = $urandom;
        if (k == v.stall + 1 && wb_cyc_o && wb_stb_o) begin
          cap_we = wb_we_o; cap_addr = wb_addr_o; cap_data = wb_data_o; cap_sel = wb_sel_o;
        end
        if (k == ack_k) begin
          wb_ack_i = (v.mode != M_ERR);
          wb_err_i = (v.mode == M_ERR || v.mode == M_BOTH);
          if (!wb_err_i) begin
            if (cap_we) slv_mem[widx(cap_addr)] = merge(slv_mem[widx(cap_addr)], cap_data, cap_sel);
            else        wb_data_i = slv_mem[widx(cap_addr)];
          end
        end
        step();
      end
    end
    wb_stall_i = 1'b0; wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_data_i = '0;
    if (got) begin
      step();
      check1({tag, " ready after rsp"}, req_ready_o, 1'b1);
      check1({tag, " single pulse"}, rsp_valid_o, 1'b0);
    end
  endtask

  task automatic run_and_check(input string tag, input vec_t v);
    logic [31:0] rd;
    logic er;
    int lat;
    run_txn(tag, v, rd, er, lat);
    check({tag, " rdata"}, rd, v.exp_rdata);
    check1({tag, " err"}, er, v.exp_err);
    check({tag, " latency"}, 32'(lat), 32'(v.exp_lat));
    check({tag, " rdata hold"}, rsp_rdata_o, v.exp_rdata);
    if (v.we && (v.mode == M_ACK || v.mode == M_ACK_TO))
      ref_mem[widx(v.addr)] = merge(ref_mem[widx(v.addr)], v.wdata, v.sel);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int w;
    int g;
    resetn = 1'b0; req_valid_i = 1'b0; req_we_i = 1'b0; req_addr_i = '0;
    req_wdata_i = '0; req_sel_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
    wb_stall_i = 1'b0; wb_data_i = '0;
    for (int i = 0; i < 16; i++) begin slv_mem[i] = '0; ref_mem[i] = '0; end

    tbl[0]  = mk(1'b1, BASE,     32'hC000_0010, 4'hF, 0, M_ACK,    32'h0,          1'b0, 3);
    tbl[1]  = mk(1'b0, BASE,     32'h0,         4'hF, 0, M_ACK,    32'hC000_0010,  1'b0, 3);
    tbl[2]  = mk(1'b1, BASE,     32'h0000_00AB, 4'h1, 0, M_ACK,    32'h0,          1'b0, 3);
    tbl[3]  = mk(1'b0, BASE,     32'h0,         4'hF, 0, M_ACK,    32'hC000_00AB,  1'b0, 3);
    tbl[4]  = mk(1'b1, BASE + 4, 32'h1234_5678, 4'hF, 5, M_ACK,    32'h0,          1'b0, 8);
    tbl[5]  = mk(1'b0, BASE + 4, 32'h0,         4'hF, 5, M_ACK,    32'h1234_5678,  1'b0, 8);
    tbl[6]  = mk(1'b0, BASE,     32'h0,         4'hF, 0, M_ERR,    32'h0,          1'b1, 3);
    tbl[7]  = mk(1'b0, BASE,     32'h0,         4'hF, 0, M_BOTH,   32'h0,          1'b1, 3);
    tbl[8]  = mk(1'b0, BASE,     32'h0,         4'hF, 0, M_NONE,   32'h0,          1'b1, TO + 2);
    tbl[9]  = mk(1'b0, BASE,     32'h0,         4'hF, 0, M_ACK_TO, 32'hC000_00AB,  1'b0, TO + 2);
    tbl[10] = mk(1'b1, BASE + 4, 32'hFFFF_FFFF, 4'hF, 0, M_ERR,    32'h0,          1'b1, 3);

    step(); step();
    check1("reset ready", req_ready_o, 1'b0);
    check1("reset cyc", wb_cyc_o, 1'b0);
    check1("reset rsp_valid", rsp_valid_o, 1'b0);
    check("reset rdata", rsp_rdata_o, 32'h0);
    resetn = 1'b1;
    step();
    check1("ready after reset", req_ready_o, 1'b1);

    for (int i = 0; i < NVEC; i++) begin
      run_and_check($sformatf("vec%0d", i), tbl[i]);
      if (tbl[i].mode == M_NONE) begin
        wb_ack_i = 1'b1; wb_data_i = 32'hDEAD_BEEF;
        for (int j = 0; j < 3; j++) begin
          check1($sformatf("late ack no rsp %0d", j), rsp_valid_o, 1'b0);
          check1($sformatf("late ack cyc %0d", j), wb_cyc_o, 1'b0);
          step();
          wb_ack_i = 1'b0;
        end
        check1("late ack no rsp end", rsp_valid_o, 1'b0);
      end
    end

    for (int i = 0; i < 30; i++) begin
      w = $urandom_range(0, 15);
      v.we = 1'($urandom);
      v.addr = BASE + 32'(w * 4);
      v.wdata = $urandom;
      v.sel = 4'($urandom_range(1, 15));
      v.stall = $urandom_range(0, 3);
      v.mode = ($urandom_range(0, 5) == 0) ? M_ERR : M_ACK;
      v.exp_err = (v.mode == M_ERR);
      v.exp_rdata = (v.mode == M_ACK && !v.we) ? ref_mem[w] : 32'h0;
      v.exp_lat = 3 + v.stall;
      run_and_check($sformatf("rnd%0d", i), v);
    end

    // Reset while in WAIT: bus drops, no response, ready right after release.
    g = 0;
    while (req_ready_o !== 1'b1 && g < 20) begin step(); g++; end
    req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = BASE + 8;
    req_wdata_i = 32'h5A5A_5A5A; req_sel_i = 4'hF;
    step();
    req_valid_i = 1'b0;
    check1("abort stb k1", wb_stb_o, 1'b1);
    step();
    check1("abort cyc k2", wb_cyc_o, 1'b1);
    check1("abort we k2", wb_we_o, 1'b1);
    resetn = 1'b0;
    step();
    check1("abort cyc", wb_cyc_o, 1'b0);
    check1("abort stb", wb_stb_o, 1'b0);
    check1("abort we", wb_we_o, 1'b0);
    check("abort addr", wb_addr_o, 32'h0);
    check("abort data", wb_data_o, 32'h0);
    check("abort sel", {28'd0, wb_sel_o}, 32'h0);
    check1("abort ready", req_ready_o, 1'b0);
    check1("abort rsp_valid", rsp_valid_o, 1'b0);
    check("abort rdata", rsp_rdata_o, 32'h0);
    check1("abort err", rsp_err_o, 1'b0);
    resetn = 1'b1; wb_ack_i = 1'b1; wb_data_i = 32'hFEED_F00D;
    step();
    wb_ack_i = 1'b0;
    check1("post-abort ready", req_ready_o, 1'b1);
    for (int j = 0; j < 3; j++) begin
      check1($sformatf("post-abort no rsp %0d", j), rsp_valid_o, 1'b0);
      step();
    end

    w = $urandom_range(0, 15);
    v = mk(1'b0, BASE + 32'(w * 4), 32'h0, 4'hF, 1, M_ACK, ref_mem[w], 1'b0, 4);
    run_and_check("recover", v);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
